// File: rtl/noc_pkg.sv
// noc_pkg: constants and encodings shared by the mesh router's input blocks
// and output arbiters.
//   NPORTS / DW  : number of router ports and the flit width
//   IW           : width of a port index (grant_id, register, ptr)
//   PORT_*       : port index encoding (0=Local, 1=N, 2=E, 3=S, 4=W)
//   arb_state_e  : output arbiter state encoding
package noc_pkg;
    localparam int NPORTS = 5;
    localparam int DW     = 8;
    localparam int IW     = 3;

    localparam logic [IW-1:0] PORT_L = 3'd0;
    localparam logic [IW-1:0] PORT_N = 3'd1;
    localparam logic [IW-1:0] PORT_E = 3'd2;
    localparam logic [IW-1:0] PORT_S = 3'd3;
    localparam logic [IW-1:0] PORT_W = 3'd4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Finds the first set bit of req, searching upward from (ptr+1) mod N with
// wrap, so the port at ptr (the one last served) has lowest priority.
//   req     in  N   requesting ports
//   ptr     in  IW  last-served port index
//   pick    out N   one-hot winner, zero when req is zero
//   pick_id out IW  index of winner, zero when req is zero
module rr_arbiter
    import noc_pkg::*;
#(
    parameter int N = NPORTS
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] pick_id
);
    int            c;
    logic [IW-1:0] ci;
    logic          hit;

    always_comb begin
        pick    = '0;
        pick_id = '0;
        hit     = 1'b0;
        c       = 0;
        ci      = '0;
        for (int k = 1; k <= N; k++) begin
            c  = (int'(ptr) + k) % N;
            ci = IW'(c);
            if (!hit && req[ci]) begin
                hit      = 1'b1;
                pick[ci] = 1'b1;
                pick_id  = ci;
            end
        end
    end
endmodule

// File: rtl/output_arbiter.sv
// output_arbiter: per-output-port switch allocator. Grants the output to one
// requesting input at a time in round-robin order, holds the grant for the
// whole packet and releases it on the tail transfer.
// Optional macro ARB_TIMEOUT_EN adds an idle-grant watchdog (parameter
// TIMEOUT, output timeout) that releases a grant whose owner stops sending.
//   clk, rst        clock, asynchronous active-high reset
//   req/tail/val_in per-input request, tail marker and flit valid
//   data_in         per-input flits, input i on [i*DW +: DW]
//   ret_out         ready back to each input (only the owner sees ret_in)
//   ret_in          downstream ready
//   val_out/data_out flit to downstream, steered from the owner
//   grant/grant_id  one-hot / index of the owner, zero when free
//   busy            port is owned
//   timeout         (ARB_TIMEOUT_EN) one-cycle pulse on a watchdog release
module output_arbiter
    import noc_pkg::*;
#(
    parameter int NPORTS = noc_pkg::NPORTS,
    parameter int DW     = noc_pkg::DW
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 15
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPORTS-1:0]    req,
    input  logic [NPORTS-1:0]    tail,
    input  logic [NPORTS-1:0]    val_in,
    input  logic [NPORTS*DW-1:0] data_in,
    output logic [NPORTS-1:0]    ret_out,
    input  logic                 ret_in,
    output logic                 val_out,
    output logic [DW-1:0]        data_out,
    output logic [NPORTS-1:0]    grant,
    output logic [IW-1:0]        grant_id,
    output logic                 busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                 timeout
`endif
);
    arb_state_e        state, state_nx;
    logic [NPORTS-1:0] grant_nx;
    logic [IW-1:0]     gid_nx;
    logic [IW-1:0]     ptr, ptr_nx;
    logic [NPORTS-1:0] pick;
    logic [IW-1:0]     pick_id;
    logic              active;
    logic              xfer;
    logic              expire;

    rr_arbiter #(.N(NPORTS)) u_rr (
        .req     (req),
        .ptr     (ptr),
        .pick    (pick),
        .pick_id (pick_id)
    );

    assign active = (state == ACTIVE);
    assign xfer   = active & val_in[grant_id] & ret_in;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;

    // Expires on the edge where the idle count would reach TIMEOUT.
    assign expire = active & ~val_in[grant_id] & (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= expire;
            // Held at zero while free, so a fresh grant starts from zero.
            if (!active || xfer)
                cnt <= '0;
            else if (!val_in[grant_id])
                cnt <= cnt + 1'b1;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            ptr      <= IW'(NPORTS - 1);
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            grant_id <= gid_nx;
            ptr      <= ptr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        gid_nx   = grant_id;
        ptr_nx   = ptr;
        busy     = active;
        val_out  = 1'b0;
        data_out = '0;
        ret_out  = '0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nx = ACTIVE;
                    grant_nx = pick;
                    gid_nx   = pick_id;
                end
            end
            ACTIVE: begin
                val_out  = val_in[grant_id];
                data_out = data_in[int'(grant_id)*DW +: DW];
                ret_out  = grant & {NPORTS{ret_in}};
                // Requests are ignored while owned; only tail or watchdog frees.
                if ((xfer && tail[grant_id]) || expire) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                    gid_nx   = '0;
                    ptr_nx   = grant_id;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_output_arbiter.sv
// Bench for output_arbiter: input blocks modelled as flit queues, a
// behavioural owner/pointer model checked on every negedge, directed
// scenarios with literal expectations, then a randomized phase.
module tb_output_arbiter;
    localparam int NPORTS  = 5;
    localparam int DW      = 8;
    localparam int TIMEOUT = 15;

    logic                 clk, rst;
    logic [NPORTS-1:0]    req, tail, val_in, ret_out, grant;
    logic [NPORTS*DW-1:0] data_in;
    logic                 ret_in, val_out, busy;
    logic [DW-1:0]        data_out;
    logic [2:0]           grant_id;
`ifdef ARB_TIMEOUT_EN
    logic                 timeout;
`endif

    output_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .tail(tail), .val_in(val_in),
        .data_in(data_in), .ret_out(ret_out), .ret_in(ret_in),
        .val_out(val_out), .data_out(data_out), .grant(grant),
        .grant_id(grant_id), .busy(busy)
`ifdef ARB_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Input block state: per-port flit queue, bit DW is the tail marker.
    logic [DW:0]       q [NPORTS][$];
    logic [NPORTS-1:0] fire = '0;
    logic [NPORTS-1:0] req_mask = '0;
    int                val_prob = 100;
    logic [DW-1:0]     out_log[$];
    int                gnt_log[$];
    int                gap_log[$];
    logic              prev_busy = 1'b0;
    int                idle_run = 0;

    // Behavioural model: who owns the port and who was served last.
    int owner = -1;
    int m_ptr = NPORTS - 1;
    int tcnt  = 0;
    bit m_to  = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [22:0] g, e;
        logic [NPORTS-1:0] eg, er;
        logic [DW-1:0] ed;
        logic ev;
        bit nt;
        if (rst) begin
            owner = -1; m_ptr = NPORTS - 1; tcnt = 0; m_to = 1'b0;
        end else begin
            eg = '0; er = '0; ed = '0; ev = 1'b0;
            if (owner >= 0) begin
                eg[owner] = 1'b1;
                er[owner] = ret_in;
                ev = val_in[owner];
                ed = data_in[owner*DW +: DW];
            end
            g = {grant, grant_id, busy, val_out, ret_out, data_out};
            e = {eg, 3'(owner < 0 ? 0 : owner), owner >= 0, ev, er, ed};
            n_chk++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t got grant=%b id=%0d busy=%b val=%b ret=%b data=%h want grant=%b id=%0d busy=%b val=%b ret=%b data=%h",
                         $time, grant, grant_id, busy, val_out, ret_out, data_out,
                         eg, owner < 0 ? 0 : owner, owner >= 0, ev, er, ed);
            end
`ifdef ARB_TIMEOUT_EN
            n_chk++;
            if (timeout !== m_to) begin
                n_fail++;
                $display("FAIL model_timeout t=%0t got %b want %b", $time, timeout, m_to);
            end
`endif
            // Predict the state after the coming edge (inputs are stable until then).
            nt = 1'b0;
            if (owner < 0) begin
                for (int k = 1; k <= NPORTS; k++)
                    if (owner < 0 && req[(m_ptr + k) % NPORTS]) owner = (m_ptr + k) % NPORTS;
                tcnt = 0;
            end else if (val_in[owner] && ret_in) begin
                tcnt = 0;
                if (tail[owner]) begin m_ptr = owner; owner = -1; end
            end else if (!val_in[owner]) begin
                tcnt++;
`ifdef ARB_TIMEOUT_EN
                if (tcnt == TIMEOUT) begin m_ptr = owner; owner = -1; nt = 1'b1; end
`endif
            end
            m_to = nt;
        end
    end

    task automatic drive();
        for (int i = 0; i < NPORTS; i++) begin
            if (q[i].size() > 0) begin
                req[i]    = ~req_mask[i];
                val_in[i] = (int'($urandom_range(99)) < val_prob);
                data_in[i*DW +: DW] = q[i][0][DW-1:0];
                tail[i]   = q[i][0][DW];
            end else begin
                req[i] = 1'b0; val_in[i] = 1'b0; tail[i] = 1'b0;
                data_in[i*DW +: DW] = '0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NPORTS; i++)
            if (fire[i]) void'(q[i].pop_front());
        drive();
        @(negedge clk);
        fire = val_in & ret_out;
        if (val_out && ret_in) out_log.push_back(data_out);
        if (busy && !prev_busy) begin
            gnt_log.push_back(int'(grant_id));
            gap_log.push_back(idle_run);
            idle_run = 0;
        end
        if (!busy) idle_run++;
        prev_busy = busy;
    endtask

    task automatic push_flit(input int i, input logic [DW-1:0] d, input logic t);
        q[i].push_back({t, d});
    endtask

    task automatic push_pkt(input int i, input int len, input logic [DW-1:0] base);
        for (int k = 0; k < len; k++) push_flit(i, base + DW'(k), k == len - 1);
    endtask

    task automatic clear_bench();
        for (int i = 0; i < NPORTS; i++) q[i].delete();
        fire = '0; req_mask = '0; ret_in = 1'b1; val_prob = 100;
        out_log.delete(); gnt_log.delete(); gap_log.delete();
        prev_busy = 1'b0; idle_run = 0;
    endtask

    // Holds reset across a negedge so the model sees it too.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        clear_bench();
        drive();
        @(posedge clk); @(negedge clk); @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_busy(input bit want, input string name);
        int n = 0;
        while (busy !== want && n < 40) begin step(); n++; end
        if (busy !== want) chk(name, 32'(busy), 32'(want));
    endtask

    initial begin
        int n, bad, tcount, bcount;
        logic [DW-1:0] exp1[4] = '{8'hAF, 8'hFA, 8'hF8, 8'hF0};
        logic [DW-1:0] exp3[4] = '{8'h10, 8'h11, 8'h12, 8'h13};
        int expg[6] = '{0, 1, 2, 3, 4, 0};

        rst = 1'b1; req = '0; tail = '0; val_in = '0; data_in = '0; ret_in = 1'b1;
        clear_bench();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_val_out", 32'(val_out), 0);
        chk("rst_ret_out", 32'(ret_out), 0);
        chk("rst_data_out", 32'(data_out), 0);

        // Single request, 4-flit packet on input N.
        push_flit(1, 8'hAF, 0); push_flit(1, 8'hFA, 0);
        push_flit(1, 8'hF8, 0); push_flit(1, 8'hF0, 1);
        step();
        chk("single_no_grant_yet", 32'(grant), 0);
        step();
        chk("single_grant", 32'(grant), 32'h02);
        chk("single_grant_id", 32'(grant_id), 1);
        wait_busy(1'b0, "single_wait_release");
        chk("single_flit_count", out_log.size(), 4);
        for (int k = 0; k < 4 && k < out_log.size(); k++)
            chk($sformatf("single_flit%0d", k), 32'(out_log[k]), 32'(exp1[k]));

        // Contention: every input sends two 2-flit packets.
        do_reset();
        for (int i = 0; i < NPORTS; i++) begin
            push_pkt(i, 2, 8'(8'h20 * i)); push_pkt(i, 2, 8'(8'h20 * i + 8'h10));
        end
        n = 0;
        while (gnt_log.size() < 6 && n < 80) begin step(); n++; end
        chk("rr_grants_seen", gnt_log.size() >= 6, 1);
        for (int k = 0; k < 6 && k < gnt_log.size(); k++) begin
            chk($sformatf("rr_order%0d", k), gnt_log[k], expg[k]);
            if (k > 0) chk($sformatf("rr_gap%0d", k), gap_log[k], 1);
        end

        // Backpressure mid-packet on input S.
        do_reset();
        for (int k = 0; k < 4; k++) push_flit(3, exp3[k], k == 3);
        n = 0;
        while (out_log.size() < 1 && n < 20) begin step(); n++; end
        ret_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_data_hold", 32'(data_out), 32'h11);
            chk("bp_ret_out", 32'(ret_out), 0);
        end
        ret_in = 1'b1;
        wait_busy(1'b0, "bp_wait_release");
        chk("bp_flit_count", out_log.size(), 4);
        for (int k = 0; k < 4 && k < out_log.size(); k++)
            chk($sformatf("bp_flit%0d", k), 32'(out_log[k]), 32'(exp3[k]));

        // Request change while owned: req[2] drops, req[4] rises.
        do_reset();
        push_pkt(2, 3, 8'h20);
        wait_busy(1'b1, "chg_wait_grant");
        chk("chg_grant2", 32'(grant), 32'h04);
        req_mask[2] = 1'b1;
        push_flit(4, 8'h40, 1);
        bad = 0; n = 0;
        while (busy && n < 20) begin
            step(); n++;
            if (busy && grant !== 5'b00100) bad++;
        end
        chk("chg_hold_grant", bad, 0);
        wait_busy(1'b1, "chg_wait_grant4");
        chk("chg_grant4", 32'(grant), 32'h10);
        wait_busy(1'b0, "chg_wait_release");
        req_mask = '0;

        // Asynchronous reset during flit 2 of input S.
        do_reset();
        push_pkt(3, 4, 8'h30);
        n = 0;
        while (out_log.size() < 1 && n < 20) begin step(); n++; end
        #2 rst = 1'b1;
        #1;
        chk("arst_grant", 32'(grant), 0);
        chk("arst_val_out", 32'(val_out), 0);
        chk("arst_ret_out", 32'(ret_out), 0);
        clear_bench();
        push_pkt(3, 2, 8'h30);
        push_flit(1, 8'h50, 1);
        drive();
        @(posedge clk); @(negedge clk); @(posedge clk);
        #1 rst = 1'b0;
        wait_busy(1'b1, "arst_wait_grant");
        chk("arst_next_grant_id", 32'(grant_id), 1);
        wait_busy(1'b0, "arst_wait_release");

`ifdef ARB_TIMEOUT_EN
        // Owner stays silent: watchdog releases and the pointer moves past it.
        do_reset();
        val_prob = 0;
        push_pkt(2, 2, 8'h60);
        push_pkt(3, 2, 8'h70);
        wait_busy(1'b1, "to_wait_grant");
        chk("to_owner", 32'(grant_id), 2);
        bcount = 0; tcount = 0; n = 0;
        while (busy && n < 40) begin
            bcount++;
            if (timeout) tcount++;
            step(); n++;
        end
        chk("to_busy_cycles", bcount, TIMEOUT);
        chk("to_pulse", 32'(timeout), 1);
        step();
        chk("to_pulse_once", 32'(timeout) + tcount, 0);
        chk("to_next_owner", 32'(grant_id), 3);
        val_prob = 100;
`endif

        // Randomized traffic checked by the model each cycle.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) val_prob = (c % 750 == 0) ? 100 : int'($urandom_range(40, 95));
            for (int i = 0; i < NPORTS; i++)
                if (q[i].size() == 0 && $urandom_range(99) < 30)
                    push_pkt(i, int'($urandom_range(1, 4)), 8'($urandom));
            ret_in   = ($urandom_range(99) < 80);
            req_mask = ($urandom_range(99) < 5) ? NPORTS'($urandom) : '0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/output_arbiter.md
# output_arbiter

Per-output-port switch allocator for the mesh router. Each router output (Local, N, E, S, W) has one instance that takes routing requests from the five input blocks, grants the port to one input at a time in round-robin order, and steers that input's flits through to the downstream link with the codebase's val/ret handshake. The grant is held for a whole packet and released on the tail flit.

## Interface
- NPORTS, 5, number of requesting input blocks; index 0=Local, 1=N, 2=E, 3=S, 4=W
- DW, 8, flit width in bits
- TIMEOUT, 15, idle-grant watchdog limit in cycles; used only with ARB_TIMEOUT_EN
- clk  in  1  router clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NPORTS  req[i]=1: input i has a packet routed to this output
- tail  in  NPORTS  tail[i]=1: flit currently on input i is the packet's last flit
- val_in  in  NPORTS  flit valid from each input block
- data_in  in  NPORTS*DW  flits, input i on bits [i*DW +: DW]
- ret_out  out  NPORTS  ready back to each input block
- ret_in  in  1  downstream ready
- val_out  out  1  flit valid to downstream
- data_out  out  DW  flit to downstream
- grant  out  NPORTS  one-hot current owner, all-zero when free
- grant_id  out  3  index of current owner, same encoding as the input block's `register` output; 0 when free
- busy  out  1  port owned, so state is ACTIVE

## Operation
- Two states: IDLE and ACTIVE. The state, grant, and round-robin pointer `ptr` are registered.
- IDLE: when |req is true, the owner is the first i with req[i]=1, searching from (ptr+1) mod NPORTS upward with wrap. On that edge grant, grant_id, and busy are loaded and the state goes to ACTIVE. When req is all-zero, the block stays in IDLE.
- ACTIVE, with owner g (combinational steering):
  - data_out = data_in[g]
  - val_out = val_in[g]
  - ret_out[g] = ret_in
  - ret_out for every other input is 0
- A transfer happens in a cycle where val_in[g] and ret_in are both 1.
- When a transfer happens with tail[g]=1, at that edge the state goes to IDLE, grant is cleared, and ptr is set to g.
- In ACTIVE, req changes from any input are ignored, including deassertion of req[g]. Only a tail transfer or a timeout releases the grant.
- IDLE outputs: val_out=0, data_out=0, ret_out=0.
- In IDLE the block never transfers, so a tail flit that arrives while the port is free is not consumed.
- Reset values:
  - state IDLE
  - grant 0, grant_id 0, busy 0
  - val_out 0, data_out 0, ret_out 0
  - ptr NPORTS-1, so port 0 has first priority
- Reset in the middle of a packet drops ownership immediately. The input block is responsible for re-sending.

## Timing
- Arbitration latency is 1 cycle: req sampled at edge k gives grant visible from edge k to k+1, and the first transfer can happen in that cycle.
- Throughput is 1 flit per cycle while val_in[g] and ret_in are both high.
- Minimum gap between packets is 1 cycle: the tail edge returns to IDLE and the next grant is loaded at the following edge.
- ret_in low stalls the transfer. data_out stays equal to data_in[g], and the input block must hold its flit.
- When several requests arrive in the same cycle, the pointer order decides. A port that was just served becomes lowest priority.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter of width clog2(TIMEOUT+1) clears on grant and on every transfer.
  - It increments in ACTIVE cycles where val_in[g]=0.
  - When it reaches TIMEOUT, at that edge the block releases exactly as for a tail transfer, with ptr=g.
  - An output timeout pulses for 1 cycle on that edge.
- ARB_TIMEOUT_EN undefined: no counter and no timeout port. The grant is held until the tail transfer.

## Structure
- noc_pkg holds NPORTS, DW, the port index constants (PORT_L/N/E/S/W), and the IDLE/ACTIVE state encoding. The input blocks share these.
- Sub-module rr_arbiter is a combinational priority pick: inputs req and ptr, output one-hot plus index.

## Test plan
- Single request: req=00010 at reset. Expected: grant=00010 and grant_id=1 one cycle later. A 4-flit packet 0xAF,0xFA,0xF8,0xF0 with tail on 0xF0 passes to data_out in 4 cycles, then busy=0.
- Contention: req=11111 held and every input sending 2-flit packets. Expected grant order 0,1,2,3,4,0, with a 1-cycle idle gap between packets.
- Backpressure: ret_in=0 for 3 cycles in mid-packet. Expected: data_out holds the flit, ret_out[g]=0, no loss or duplication, and the packet finishes after ret_in returns.
- Request change while owned: port 2 owns the grant and req[2] drops while req[4] rises. Expected: grant stays 00100 until the tail transfer, then goes to 10000.
- Reset mid-packet: rst pulse during flit 2. Expected: grant=0, val_out=0, and ret_out=0 asynchronously. The next grant goes to the lowest-indexed requester.
- With ARB_TIMEOUT_EN and TIMEOUT=15: owner holds val_in=0 for 15 cycles. Expected: timeout pulses once, the grant is released, and ptr moves past the owner.
